// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory store buffer.
package dmem_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 7;
    localparam int SB_DW    = 32;

    localparam logic ACT_LO   = 1'b0;
    localparam logic INACT_LO = 1'b1;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        CYC_IDLE,
        CYC_LOAD,
        CYC_STORE
    } cyc_e;

endpackage

// File: rtl/sb_fifo.sv
// Circular store-buffer array with address CAM, in-place data update and FIFO pop/push.
module sb_fifo
    import dmem_pkg::*;
#(
    parameter int  DEPTH = SB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [SB_AW-1:0] push_addr_i,
    input  logic [SB_DW-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             wr_en_i,
    input  logic [PW-1:0]    wr_idx_i,
    input  logic [SB_DW-1:0] wr_data_i,
    input  logic [SB_AW-1:0] match_addr_i,
    output logic             match_any_o,
    output logic [PW-1:0]    match_idx_o,
    output logic [SB_DW-1:0] match_data_o,
    output logic [PW-1:0]    head_idx_o,
    output logic [SB_AW-1:0] head_addr_o,
    output logic [SB_DW-1:0] head_data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    sb_entry_t        entries_q [DEPTH];
    sb_entry_t        entries_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] match_vec;

    // Coalescing keeps addresses unique, so the encoder sees at most one bit set.
    always_comb begin
        match_idx_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = entries_q[i].valid && (entries_q[i].addr == match_addr_i);
            if (match_vec[i]) begin
                match_idx_o = PW'(i);
            end
        end
        match_any_o = |match_vec;
    end

    assign match_data_o = entries_q[match_idx_o].data;
    assign head_idx_o   = head_q;
    assign head_addr_o  = entries_q[head_q].addr;
    assign head_data_o  = entries_q[head_q].data;
    assign count_o      = count_q;
    assign empty_o      = (count_q == '0);

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (wr_en_i) begin
            entries_d[wr_idx_i].data = wr_data_i;
        end
        if (pop_i) begin
            entries_d[head_q].valid = 1'b0;
            head_d = head_q + PW'(1);
        end
        // When full, pop and push hit the same slot; the push is applied last and wins.
        if (push_i) begin
            entries_d[tail_q] = '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
            tail_d = tail_q + PW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: only the valid bits need reset; addr/data are ignored while invalid.
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Coalescing store buffer between the core data port and the 128x32 SRAM; loads forward same cycle.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int  DEPTH = SB_DEPTH,
    localparam int AW    = SB_AW,
    localparam int DW    = SB_DW,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CEN,
    input  logic          WEN,
    input  logic          OEN,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] Data2Mem,
    output logic [DW-1:0] ReadDataMem,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q,
    output logic [CW-1:0] buf_count,
    output logic          buf_empty
);

    cyc_e          cyc;
    logic          hit;
    logic          head_hit;
    logic          drain;
    logic          push;
    logic          wr_en;
    logic [PW-1:0] match_idx;
    logic [DW-1:0] match_data;
    logic [PW-1:0] head_idx;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [AW-1:0] sram_a_q;
    logic [DW-1:0] sram_d_q;

    always_comb begin
        cyc = CYC_IDLE;
        if (CEN == ACT_LO && WEN == ACT_LO) begin
            cyc = CYC_STORE;
        end else if (CEN == ACT_LO && OEN == ACT_LO) begin
            cyc = CYC_LOAD;
        end
    end

    // Any non-load cycle leaves the SRAM port free, so the head drains whenever present.
    assign head_hit = hit && (match_idx == head_idx);
    assign drain    = !rst && !buf_empty && (cyc != CYC_LOAD);
    assign push     = !rst && (cyc == CYC_STORE) && !hit;
    assign wr_en    = !rst && (cyc == CYC_STORE) && hit && !head_hit;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_addr_i  (A),
        .push_data_i  (Data2Mem),
        .pop_i        (drain),
        .wr_en_i      (wr_en),
        .wr_idx_i     (match_idx),
        .wr_data_i    (Data2Mem),
        .match_addr_i (A),
        .match_any_o  (hit),
        .match_idx_o  (match_idx),
        .match_data_o (match_data),
        .head_idx_o   (head_idx),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .count_o      (buf_count),
        .empty_o      (buf_empty)
    );

    always_comb begin
        sram_cen = INACT_LO;
        sram_wen = INACT_LO;
        sram_a   = sram_a_q;
        sram_d   = sram_d_q;
        if (!rst) begin
            if (cyc == CYC_LOAD) begin
                sram_cen = ACT_LO;
                sram_a   = A;
            end else if (drain) begin
                sram_cen = ACT_LO;
                sram_wen = ACT_LO;
                sram_a   = head_addr;
                // A store to the head address bypasses the entry and goes straight out.
                sram_d   = (cyc == CYC_STORE && head_hit) ? Data2Mem : head_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_a_q <= '0;
            sram_d_q <= '0;
        end else begin
            sram_a_q <= sram_a;
            sram_d_q <= sram_d;
        end
    end

    always_comb begin
        ReadDataMem = '0;
        if (!rst) begin
            ReadDataMem = hit ? match_data : sram_q;
        end
    end

endmodule
